// File: rtl/instr_mem_responder_pkg.sv
// ============================================================================
// Module      : instr_mem_pkg
// Description : Shared constants and FSM state type for instr_mem_responder.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_mem_pkg;

  localparam logic [6:0]  OPC_HALT       = 7'b1111111;
  localparam logic [31:0] HALT_INSN      = {25'd0, OPC_HALT};
  localparam int          BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_mem_responder_if.sv
// ============================================================================
// Module      : instr_mem_responder_if
// Description : Program-load and fetch signals between the PC side and the
//               instruction memory responder.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_mem_responder_if #(
  parameter int WIDTH = 32
);

  logic             load_en;
  logic             load_valid;
  logic [7:0]       load_byte;
  logic             load_ready;
  logic             load_done;
  logic [WIDTH-1:0] ins_add;
  logic [31:0]      instruction;
  logic             ins_valid;
  logic             addr_err;
  logic             par_err;

  modport master (
    output load_en, load_valid, load_byte, ins_add,
    input  load_ready, load_done, instruction, ins_valid, addr_err, par_err
  );

  modport slave (
    input  load_en, load_valid, load_byte, ins_add,
    output load_ready, load_done, instruction, ins_valid, addr_err, par_err
  );

endinterface

`default_nettype wire

// File: rtl/instr_mem_responder_packer.sv
// ============================================================================
// Module      : load_byte_packer
// Description : Collects little-endian program bytes into 32-bit words.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_byte_packer
  import instr_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_strobe
);

  localparam logic [1:0] c_LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_cnt;
  logic [23:0] r_asm;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= 2'd0;
      r_asm <= 24'd0;
    end else if (i_valid) begin
      r_cnt <= r_cnt + 2'd1;
      case (r_cnt)
        2'd0:    r_asm[7:0]   <= i_byte;
        2'd1:    r_asm[15:8]  <= i_byte;
        2'd2:    r_asm[23:16] <= i_byte;
        default: ;
      endcase
    end
  end

  // The top lane bypasses the register so the word is written on its last byte.
  assign o_word        = {i_byte, r_asm};
  assign o_word_strobe = i_valid && (r_cnt == c_LAST_LANE);

endmodule

`default_nettype wire

// File: rtl/instr_mem_responder.sv
// ============================================================================
// Module      : instr_mem_responder
// Description : Byte-loaded instruction RAM answering PC fetches one cycle
//               later; HALT is returned whenever no valid word exists.
//               Optional macro FETCH_PARITY_EN adds per-word even parity.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_mem_responder_if.slave  bus
);

  localparam int               c_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               c_IW      = ADDR_W - 2;
  localparam logic [c_IW:0]    c_DEPTH_X = (c_IW + 1)'(DEPTH);
  localparam logic [c_AW:0]    c_PTR_MAX = (c_AW + 1)'(DEPTH);

  state_t          r_state;
  state_t          w_next;
  logic [c_AW:0]   r_ptr;
  logic [31:0]     r_mem [DEPTH];
  logic [31:0]     r_instr;
  logic            r_ins_valid;
  logic            r_addr_err;
  logic            r_load_done;

  logic            w_load_ready;
  logic            w_enter_load;
  logic            w_accept;
  logic [31:0]     w_word;
  logic            w_strobe;
  logic            w_fetch;
  logic [c_IW-1:0] w_idx;
  logic            w_bad_addr;
  logic            w_par_bad;
  logic [31:0]     w_rd;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_load_ready = 1'b0;
    w_enter_load = 1'b0;
    case (r_state)
      IDLE: if (bus.load_en) begin
        w_next       = LOAD;
        w_enter_load = 1'b1;
      end
      LOAD: begin
        w_load_ready = (r_ptr < c_PTR_MAX);
        if (!bus.load_en) w_next = RUN;
      end
      RUN: if (bus.load_en) begin
        w_next       = LOAD;
        w_enter_load = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept = bus.load_valid && w_load_ready;

  load_byte_packer u_packer (
    .clk           (clk),
    .rst           (rst),
    .i_clear       (w_enter_load),
    .i_valid       (w_accept),
    .i_byte        (bus.load_byte),
    .o_word        (w_word),
    .o_word_strobe (w_strobe)
  );

  always_ff @(posedge clk) begin
    if (rst || w_enter_load) r_ptr <= '0;
    else if (w_strobe)       r_ptr <= r_ptr + 1'b1;
  end

  // RAM survives reset so a program can be rerun without reloading.
  always_ff @(posedge clk) begin
    if (w_strobe) r_mem[r_ptr[c_AW-1:0]] <= w_word;
  end

  always_ff @(posedge clk) begin
    if (rst) r_load_done <= 1'b0;
    else     r_load_done <= (r_state == LOAD) && !bus.load_en;
  end

  assign w_idx      = bus.ins_add[ADDR_W-1:2];
  assign w_bad_addr = (|bus.ins_add[1:0]) || (|bus.ins_add[WIDTH-1:ADDR_W])
                      || ({1'b0, w_idx} >= c_DEPTH_X);
  assign w_rd       = r_mem[w_idx[c_AW-1:0]];
  assign w_fetch    = (r_state == RUN) && !bus.load_en;

`ifdef FETCH_PARITY_EN
  logic [DEPTH-1:0] r_par;
  logic             r_par_err;

  always_ff @(posedge clk) begin
    if (w_strobe) r_par[r_ptr[c_AW-1:0]] <= ^w_word;
  end

  assign w_par_bad = ((^w_rd) != r_par[w_idx[c_AW-1:0]]);

  always_ff @(posedge clk) begin
    if (rst || w_enter_load)                   r_par_err <= 1'b0;
    else if (w_fetch && !w_bad_addr && w_par_bad) r_par_err <= 1'b1;
  end

  assign bus.par_err = r_par_err;
`else
  assign w_par_bad   = 1'b0;
  assign bus.par_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || !w_fetch) begin
      r_instr     <= HALT_INSN;
      r_ins_valid <= 1'b0;
      r_addr_err  <= 1'b0;
    end else if (w_bad_addr) begin
      r_instr     <= HALT_INSN;
      r_ins_valid <= 1'b0;
      r_addr_err  <= 1'b1;
    end else if (w_par_bad) begin
      r_instr     <= HALT_INSN;
      r_ins_valid <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_instr     <= w_rd;
      r_ins_valid <= 1'b1;
      r_addr_err  <= 1'b0;
    end
  end

  assign bus.load_ready  = w_load_ready;
  assign bus.load_done   = r_load_done;
  assign bus.instruction = r_instr;
  assign bus.ins_valid   = r_ins_valid;
  assign bus.addr_err    = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
// ============================================================================
// Module      : tb_instr_mem_responder
// Description : Self-checking bench for instr_mem_responder with a word-level
//               reference model compared every cycle.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_responder;

  localparam logic [31:0] c_HALT = 32'h0000_007F;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_mem_responder_if #(.WIDTH(32)) bus ();

  instr_mem_responder #(.WIDTH(32), .DEPTH(16), .ADDR_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: mode, accepted-byte queue, word memory with known flags.
  int          mode = M_IDLE;
  int          m_ptr = 0;
  logic [7:0]  m_q[$];
  logic [31:0] m_mem   [16];
  bit          m_known [16];
  bit          m_flip  [16];
  logic [31:0] e_ins;
  logic        e_val, e_err, e_done, e_rdy, e_par, e_chk_ins;
  bit          armed = 0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_known[i] = 0;
      m_flip[i]  = 0;
    end
    e_par = 0;
  end

  always @(posedge clk) begin
    logic [31:0] a;
    int idx;
    a = bus.ins_add;
    idx = int'(a[6:2]);
    e_ins = c_HALT; e_val = 0; e_err = 0; e_chk_ins = 1;
    if (rst) begin
      e_done = 0; e_par = 0; mode = M_IDLE;
    end else begin
      e_done = (mode == M_LOAD) && !bus.load_en;
      if (mode == M_RUN && !bus.load_en) begin
        if (a[1:0] != 0 || a[31:7] != 0 || idx >= 16) e_err = 1;
        else if (m_flip[idx]) e_par = 1;
        else begin
          e_val = 1; e_ins = m_mem[idx]; e_chk_ins = m_known[idx];
        end
      end
      if (mode == M_LOAD && bus.load_valid && m_ptr < 16) begin
        m_q.push_back(bus.load_byte);
        if (m_q.size() == 4) begin
          m_mem[m_ptr]   = {m_q[3], m_q[2], m_q[1], m_q[0]};
          m_known[m_ptr] = 1;
          m_flip[m_ptr]  = 0;
          m_ptr++;
          m_q.delete();
        end
      end
      if (bus.load_en && mode != M_LOAD) begin
        mode = M_LOAD; m_ptr = 0; m_q.delete(); e_par = 0;
      end else if (!bus.load_en && mode == M_LOAD) begin
        mode = M_RUN;
      end
    end
    e_rdy = (mode == M_LOAD) && (m_ptr < 16);
    armed = 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      if (e_chk_ins) check("instruction", bus.instruction, e_ins);
      check("ins_valid", 32'(bus.ins_valid), 32'(e_val));
      check("addr_err", 32'(bus.addr_err), 32'(e_err));
      check("par_err", 32'(bus.par_err), 32'(e_par));
      check("load_ready", 32'(bus.load_ready), 32'(e_rdy));
      check("load_done", 32'(bus.load_done), 32'(e_done));
      if (bus.load_done === 1'b1) n_done++;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    bus.load_valid = 1'b1;
    bus.load_byte  = b;
    step();
    bus.load_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp_ins, input logic exp_err, input string name);
    bus.ins_add = a;
    step();
    check(name, bus.instruction, exp_ins);
    check({name, "_err"}, 32'(bus.addr_err), 32'(exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] prog [8];
    logic [7:0] part [6];
    int d0;
    prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    part = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};

    rst = 1'b1;
    bus.load_en = 0; bus.load_valid = 0; bus.load_byte = 0; bus.ins_add = 0;
    step(); step();
    check("rst_instruction", bus.instruction, c_HALT);
    check("rst_ins_valid", 32'(bus.ins_valid), 32'd0);
    check("rst_load_ready", 32'(bus.load_ready), 32'd0);
    rst = 1'b0;
    step();
    check("idle_instruction", bus.instruction, c_HALT);

    // Two-word program load
    bus.load_en = 1'b1;
    step();
    for (int i = 0; i < 8; i++) send(prog[i]);
    bus.load_en = 1'b0;
    d0 = n_done;
    step();
    fetch(32'd0, 32'h0000_0013, 1'b0, "prog_w0");
    check("prog_w0_valid", 32'(bus.ins_valid), 32'd1);
    fetch(32'd4, 32'h0010_0093, 1'b0, "prog_w1");
    check("prog_w1_valid", 32'(bus.ins_valid), 32'd1);
    check("load_done_pulses", 32'(n_done - d0), 32'd1);

    // Partial second word is discarded
    bus.load_en = 1'b1;
    step();
    for (int i = 0; i < 6; i++) send(part[i]);
    bus.load_en = 1'b0;
    step();
    fetch(32'd0, 32'hDDCC_BBAA, 1'b0, "part_w0");
    fetch(32'd4, 32'h0010_0093, 1'b0, "part_w1");

    // Overfill: 70 bytes into 16 words
    bus.load_en = 1'b1;
    step();
    for (int i = 0; i < 70; i++) begin
      send(8'(i));
      if (i == 62) check("full_ready_before", 32'(bus.load_ready), 32'd1);
      if (i == 63) check("full_ready_after", 32'(bus.load_ready), 32'd0);
    end
    bus.load_en = 1'b0;
    step();

    fetch(32'd2,           c_HALT,        1'b1, "misaligned");
    fetch(32'd64,          c_HALT,        1'b1, "out_of_range");
    fetch(32'd60,          32'h3F3E_3D3C, 1'b0, "last_word");
    fetch(32'h1000_0000,   c_HALT,        1'b1, "high_bits");
    fetch(32'd63,          c_HALT,        1'b1, "misaligned_hi");
    fetch(32'd8,           32'h0B0A_0908, 1'b0, "word2");

    // RUN -> LOAD, then reset mid-load after three bytes
    bus.ins_add = 32'd60;
    bus.load_en = 1'b1;
    step();
    step();
    check("reload_halt", bus.instruction, c_HALT);
    for (int i = 0; i < 3; i++) send(8'hE0 + 8'(i));
    rst = 1'b1;
    bus.load_en = 1'b0;
    step();
    check("midrst_instruction", bus.instruction, c_HALT);
    check("midrst_load_ready", 32'(bus.load_ready), 32'd0);
    rst = 1'b0;
    step();
    bus.load_en = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) send(8'(i));
    bus.load_en = 1'b0;
    step();
    fetch(32'd0, 32'h0403_0201, 1'b0, "reload_w0");
    fetch(32'd4, 32'h0706_0504, 1'b0, "reload_w1");

`ifdef FETCH_PARITY_EN
    dut.r_par[0] = ~dut.r_par[0];
    m_flip[0] = 1;
    fetch(32'd0, c_HALT, 1'b0, "parity_halt");
    check("parity_err", 32'(bus.par_err), 32'd1);
    fetch(32'd4, 32'h0706_0504, 1'b0, "parity_sticky_w1");
    check("parity_sticky", 32'(bus.par_err), 32'd1);
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Instruction-side responder to the program counter: accepts the PC address each cycle and returns the 32-bit instruction one cycle later.
- Holds a small word-addressed instruction RAM.
- The RAM is loaded through a byte-serial program-load port, suited to the Tiny Tapeout pin budget.
- Returns a halt instruction (opcode 7'b1111111) whenever no valid instruction exists, so the PC freezes.

Parameters:
- WIDTH, 32, PC/address width and instruction width.
- DEPTH, 16, number of instruction words stored (power of two, 2..32).
- ADDR_W, 7, number of low PC bits decoded; matches the 7-bit jump-address field.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- load_en  input  1  level; high requests program-load mode.
- load_valid  input  1  load_byte is valid this cycle.
- load_byte  input  8  program byte; little-endian within each word.
- load_ready  output  1  byte accepted when load_valid && load_ready.
- load_done  output  1  one-cycle pulse when loading ends.
- ins_add  input  WIDTH  current instruction address from the PC.
- instruction  output  32  fetched instruction, registered.
- ins_valid  output  1  instruction holds real RAM content.
- addr_err  output  1  registered; misaligned or out-of-range fetch.
- par_err  output  1  parity error flag; 0 unless FETCH_PARITY_EN.

Behaviour:
- Reset (rst high at posedge), from any state, including mid-load:
  - state=IDLE, byte counter=0, word pointer=0.
  - instruction=32'h0000_007F (HALT), ins_valid=0, addr_err=0, par_err=0, load_ready=0, load_done=0.
  - RAM contents are not cleared.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: load_en=1 -> LOAD; otherwise stay. Output HALT.
  - LOAD: load_ready=1 while word pointer < DEPTH.
    - Each accepted byte goes to lane byte_cnt; byte_cnt increments mod 4.
    - On the 4th byte, the assembled word is written to RAM[ptr] in the same cycle and ptr increments.
    - When ptr reaches DEPTH, load_ready drops and further bytes are ignored.
    - load_en=0 -> RUN with a one-cycle load_done pulse; any partial word is discarded.
    - Output stays HALT throughout LOAD.
  - RUN: load_en=1 -> LOAD with ptr=0 and byte_cnt=0; the instruction register shows HALT from the next cycle.
- Fetch in RUN, latency 1 cycle. Index = ins_add[ADDR_W-1:2].
  - ins_add[1:0]!=0 -> HALT, addr_err=1, ins_valid=0.
  - index >= DEPTH, or ins_add bits above ADDR_W-1 nonzero -> HALT, addr_err=1, ins_valid=0.
  - Otherwise instruction=RAM[index], ins_valid=1, addr_err=0.
- Simultaneous load write and fetch: not possible; fetch happens only in RUN.
- Words never loaded return whatever the RAM holds, with ins_valid=1. Software is responsible for loading them.

Optional Feature:
- Macro FETCH_PARITY_EN.
- Defined:
  - An even-parity bit per word is computed at write and stored alongside the word.
  - On fetch, a mismatch outputs HALT, sets par_err=1 and ins_valid=0.
  - par_err is sticky until reset or the next LOAD entry.
- Undefined: no parity storage; par_err tied 0.

Decomposition:
- Shared package instr_mem_pkg holds:
  - HALT_INSN = 32'h0000_007F.
  - OPC_HALT = 7'b1111111.
  - FSM state encodings (IDLE=2'd0, LOAD=2'd1, RUN=2'd2).
  - BYTES_PER_WORD = 4.
- One sub-module, load_byte_packer: byte counter plus 32-bit assembly register. It outputs word and word_strobe, and clears on rst or load restart.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, ins_add=0 -> instruction=32'h0000_007F, ins_valid=0, load_ready=0.
- Load 8 bytes 13 00 00 00 93 00 10 00, drop load_en:
  - load_done pulses once.
  - ins_add=0 -> 32'h0000_0013 one cycle later; ins_add=4 -> 32'h0010_0093; ins_valid=1 both.
- Partial word: load 6 bytes then drop load_en -> only word 0 written; word 1 keeps its prior content.
- Full memory: DEPTH=16, send 70 bytes -> load_ready falls after byte 64; bytes 65-70 ignored; word 15 intact.
- Bad address: ins_add=2 -> HALT, addr_err=1; ins_add=64 -> HALT, addr_err=1; ins_add=60 -> RAM[15], addr_err=0.
- Reset mid-load after 3 bytes -> IDLE, HALT output, byte_cnt=0. Reload writes word 0 from the first new byte.
- With FETCH_PARITY_EN: force a stored parity bit flip on word 0 -> ins_add=0 gives HALT, par_err=1 until reset.
